// File: rtl/ieee_to_int.sv
// Serial IEEE-754 double to signed integer converter, truncating toward zero.
// Shares the load / wait-done / ack handshake of int_to_ieee.
module ieee_to_int #(
   parameter int OUT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [63:0]      a_in,
   input  logic             a_in_done,
   input  logic             z_out_ack,
   output logic             z_out_done,
   output logic [OUT_W-1:0] z_out,
   output logic             z_ovf,
   output logic             z_nan
);

   typedef enum logic [2:0] {
      IDLE,
      UNPACK,
      CLASSIFY,
      SHIFT,
      NEGATE,
      OUTPUT
   } state_t;

   localparam logic signed [11:0] E_TOP = 12'(OUT_W - 1);
   localparam logic signed [11:0] E_52  = 12'sd52;
   localparam logic [OUT_W-1:0] Z_MIN = {1'b1, {(OUT_W-1){1'b0}}};
   localparam logic [OUT_W-1:0] Z_MAX = {1'b0, {(OUT_W-1){1'b1}}};

   state_t state, next_state;

   logic [63:0]        a_reg;
   logic               sign;
   logic [10:0]        exp_val;
   logic [52:0]        mant;
   logic signed [11:0] e;
   logic [5:0]         cnt;

   logic frac_zero, is_nan, is_inf, is_zero, is_min, is_sat, is_special;

   // Operand classification; priority is resolved by the order of use below.
   always_comb begin
      frac_zero  = (mant[51:0] == 52'd0);
      is_nan     = (exp_val == 11'd2047) && !frac_zero;
      is_inf     = (exp_val == 11'd2047) && frac_zero;
      is_zero    = (exp_val == 11'd0) || (e < 12'sd0);
      is_min     = (e == E_TOP) && sign && frac_zero;
      is_sat     = (e >= E_TOP);
      is_special = is_nan || is_inf || is_zero || is_min || is_sat;
   end

   always_ff @(posedge clk) begin
      if (reset)
         state <= IDLE;
      else
         state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:     if (a_in_done) next_state = UNPACK;
         UNPACK:   next_state = CLASSIFY;
         CLASSIFY: next_state = is_special ? OUTPUT : SHIFT;
         SHIFT:    if (cnt == 6'd1) next_state = NEGATE;
         NEGATE:   next_state = OUTPUT;
         OUTPUT:   if (z_out_ack) next_state = IDLE;
         default:  next_state = IDLE;
      endcase
   end

   // Datapath; results persist after ack until the next conversion rewrites them.
   always_ff @(posedge clk) begin
      if (reset) begin
         a_reg      <= '0;
         sign       <= 1'b0;
         exp_val    <= '0;
         mant       <= '0;
         e          <= '0;
         cnt        <= '0;
         z_out      <= '0;
         z_ovf      <= 1'b0;
         z_nan      <= 1'b0;
         z_out_done <= 1'b0;
      end else begin
         z_out_done <= (next_state == OUTPUT);
         case (state)
            IDLE: if (a_in_done) a_reg <= a_in;
            UNPACK: begin
               sign    <= a_reg[63];
               exp_val <= a_reg[62:52];
               mant    <= {1'b1, a_reg[51:0]};
               e       <= $signed({1'b0, a_reg[62:52]}) - 12'sd1023;
            end
            CLASSIFY: begin
               if (is_nan) begin
                  z_out <= '0;
                  z_ovf <= 1'b0;
                  z_nan <= 1'b1;
               end else if (is_inf) begin
                  z_out <= sign ? Z_MIN : Z_MAX;
                  z_ovf <= 1'b1;
                  z_nan <= 1'b0;
               end else if (is_zero) begin
                  z_out <= '0;
                  z_ovf <= 1'b0;
                  z_nan <= 1'b0;
               end else if (is_min) begin
                  z_out <= Z_MIN;
                  z_ovf <= 1'b0;
                  z_nan <= 1'b0;
               end else if (is_sat) begin
                  z_out <= sign ? Z_MIN : Z_MAX;
                  z_ovf <= 1'b1;
                  z_nan <= 1'b0;
               end else begin
                  cnt <= 6'(E_52 - e);
               end
            end
            SHIFT: begin
               mant <= mant >> 1;
               cnt  <= cnt - 6'd1;
            end
            NEGATE: begin
               z_out <= sign ? -mant[OUT_W-1:0] : mant[OUT_W-1:0];
               z_ovf <= 1'b0;
               z_nan <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ieee_to_int.sv
// Directed testbench for ieee_to_int with OUT_W=16: values, latency,
// handshake hold/rearm and mid-conversion reset.
module tb_ieee_to_int;

   logic        clk = 1'b0;
   logic        reset;
   logic [63:0] a_in;
   logic        a_in_done;
   logic        z_out_ack;
   logic        z_out_done;
   logic [15:0] z_out;
   logic        z_ovf;
   logic        z_nan;

   int checks = 0;
   int errors = 0;

   ieee_to_int #(.OUT_W(16)) dut (
      .clk        (clk),
      .reset      (reset),
      .a_in       (a_in),
      .a_in_done  (a_in_done),
      .z_out_ack  (z_out_ack),
      .z_out_done (z_out_done),
      .z_out      (z_out),
      .z_ovf      (z_ovf),
      .z_nan      (z_nan)
   );

   always #5 clk = ~clk;

   // Vector table: operand, expected result, flags, cycle of first done.
   localparam int NV = 14;
   logic [63:0] va   [NV] = '{64'h3FF0000000000000, 64'h4059300000000000,
                              64'hC004000000000000, 64'h3FE0000000000000,
                              64'h40E3880000000000, 64'hC0E0000000000000,
                              64'hFFF0000000000000, 64'h7FF8000000000000,
                              64'h8000000000000000, 64'h40DFFFC000000000,
                              64'h7FF0000000000000, 64'h3FFFFFFFFFFFFFFF,
                              64'hC0DFFFC000000000, 64'h40E0000000000000};
   logic [15:0] vz   [NV] = '{16'h0001, 16'h0064, 16'hFFFE, 16'h0000,
                              16'h7FFF, 16'h8000, 16'h8000, 16'h0000,
                              16'h0000, 16'h7FFF, 16'h7FFF, 16'h0001,
                              16'h8001, 16'h7FFF};
   logic        vovf [NV] = '{0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 1, 0, 0, 1};
   logic        vnan [NV] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
   int          vcyc [NV] = '{56, 50, 55, 3, 3, 3, 3, 3, 3, 42, 3, 56, 42, 3};

   // Starts a conversion; cyc returns the cycle in which done was first seen.
   task automatic start_and_wait(input logic [63:0] val, output int cyc);
      a_in      = val;
      a_in_done = 1'b1;
      cyc       = 0;
      while (!z_out_done && cyc < 200) begin
         @(posedge clk);
         #1;
         cyc++;
      end
   endtask

   task automatic do_ack();
      a_in_done = 1'b0;
      z_out_ack = 1'b1;
      @(posedge clk);
      #1;
      z_out_ack = 1'b0;
   endtask

   task automatic test_reset();
      reset     = 1'b1;
      a_in      = '0;
      a_in_done = 1'b0;
      z_out_ack = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      checks++;
      if ({z_out_done, z_out, z_ovf, z_nan} !== 19'd0) begin
         errors++;
         $display("[TB] FAIL reset_outputs: got done=%0b z=%h ovf=%0b nan=%0b, want all 0",
                  z_out_done, z_out, z_ovf, z_nan);
      end
   endtask

   task automatic test_vectors();
      int cyc;
      for (int i = 0; i < NV; i++) begin
         start_and_wait(va[i], cyc);
         checks++;
         if (cyc !== vcyc[i]) begin
            errors++;
            $display("[TB] FAIL latency[%0d]: got %0d, want %0d", i, cyc, vcyc[i]);
         end
         checks++;
         if (z_out !== vz[i]) begin
            errors++;
            $display("[TB] FAIL z_out[%0d]: got %h, want %h", i, z_out, vz[i]);
         end
         checks++;
         if (z_ovf !== vovf[i]) begin
            errors++;
            $display("[TB] FAIL z_ovf[%0d]: got %0b, want %0b", i, z_ovf, vovf[i]);
         end
         checks++;
         if (z_nan !== vnan[i]) begin
            errors++;
            $display("[TB] FAIL z_nan[%0d]: got %0b, want %0b", i, z_nan, vnan[i]);
         end
         do_ack();
         checks++;
         if (z_out_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ack_drop[%0d]: got done=%0b, want 0", i, z_out_done);
         end
      end
      repeat (3) begin
         @(posedge clk);
         #1;
         checks++;
         if (z_out_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_quiet: got done=%0b, want 0", z_out_done);
         end
      end
   endtask

   task automatic test_back_to_back();
      int cyc;
      int bad;
      start_and_wait(64'h4059300000000000, cyc);
      checks++;
      if (cyc !== 50 || z_out !== 16'h0064) begin
         errors++;
         $display("[TB] FAIL hold_setup: got cyc=%0d z=%h, want 50 0064", cyc, z_out);
      end
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         a_in      = {$urandom, $urandom};
         a_in_done = i[0];
         @(posedge clk);
         #1;
         if (z_out_done !== 1'b1 || z_out !== 16'h0064 || z_ovf !== 1'b0 || z_nan !== 1'b0)
            bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("[TB] FAIL hold_stable: got %0d unstable cycles, want 0", bad);
      end
      // Ack with a_in_done still high: the next conversion starts straight from IDLE.
      a_in      = 64'hC004000000000000;
      a_in_done = 1'b1;
      z_out_ack = 1'b1;
      @(posedge clk);
      #1;
      z_out_ack = 1'b0;
      checks++;
      if (z_out_done !== 1'b0 || z_out !== 16'h0064) begin
         errors++;
         $display("[TB] FAIL rearm_ack: got done=%0b z=%h, want 0 0064", z_out_done, z_out);
      end
      start_and_wait(64'hC004000000000000, cyc);
      checks++;
      if (cyc !== 55 || z_out !== 16'hFFFE) begin
         errors++;
         $display("[TB] FAIL rearm_conv: got cyc=%0d z=%h, want 55 fffe", cyc, z_out);
      end
      do_ack();
   endtask

   task automatic test_reset_mid_shift();
      int cyc;
      int seen;
      a_in      = 64'h3FF0000000000000;
      a_in_done = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      reset     = 1'b1;
      a_in_done = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      checks++;
      if ({z_out_done, z_out, z_ovf, z_nan} !== 19'd0) begin
         errors++;
         $display("[TB] FAIL mid_reset: got done=%0b z=%h ovf=%0b nan=%0b, want all 0",
                  z_out_done, z_out, z_ovf, z_nan);
      end
      seen = 0;
      repeat (60) begin
         @(posedge clk);
         #1;
         if (z_out_done) seen++;
      end
      checks++;
      if (seen != 0) begin
         errors++;
         $display("[TB] FAIL mid_reset_nodone: got %0d done cycles, want 0", seen);
      end
      start_and_wait(64'h3FF0000000000000, cyc);
      checks++;
      if (cyc !== 56 || z_out !== 16'h0001 || z_ovf !== 1'b0 || z_nan !== 1'b0) begin
         errors++;
         $display("[TB] FAIL post_reset_conv: got cyc=%0d z=%h ovf=%0b nan=%0b, want 56 0001 0 0",
                  cyc, z_out, z_ovf, z_nan);
      end
      do_ack();
   endtask

   initial begin
      test_reset();
      test_vectors();
      test_back_to_back();
      test_reset_mid_shift();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ieee_to_int.md
Name: ieee_to_int

Overview:
- Serial converter from IEEE-754 double to a signed two's-complement integer, rounding toward zero (C-cast semantics).
- It is the return path of the color pipeline: it takes a floating-point result (e.g. an RGB-scaled value) and produces an integer for the color mapper's data_out.
- It uses the same handshake as the existing int_to_ieee unit, so a caller FSM can drive either unit with the same load / wait-done / ack sequence.

Parameters:
- OUT_W, 16, width of integer result; legal range 2..32.

Ports:
- clk, input, 1, single clock for all logic.
- reset, input, 1, synchronous, active-high; one clock, reset is synchronous and active-high.
- a_in, input, 64, IEEE-754 double operand; sampled only on the accept cycle.
- a_in_done, input, 1, operand valid (level); caller holds it high until z_out_done.
- z_out_ack, input, 1, caller acknowledges the result; meaningful only while z_out_done=1.
- z_out_done, output, 1, result valid; held until acked.
- z_out, output, OUT_W, signed integer result.
- z_ovf, output, 1, result saturated (|value| out of range, or ±Inf).
- z_nan, output, 1, operand was NaN; z_out=0.

Behaviour:
- Reset: state=IDLE; z_out_done=0, z_out=0, z_ovf=0, z_nan=0; internal regs cleared. Reset overrides every state, including mid-SHIFT; the in-flight operand is discarded and no done is produced.
- States: IDLE, UNPACK, CLASSIFY, SHIFT, NEGATE, OUTPUT.
- IDLE: if a_in_done=1, latch a_in → UNPACK. Otherwise stay.
- UNPACK (1 cycle): sign=a[63], exp=a[62:52], mant={1,a[51:0]} (53b); e=exp-1023 (signed 12b) → CLASSIFY.
- CLASSIFY (1 cycle), first matching rule wins:
  - exp=2047 and frac≠0 → z=0, z_nan=1 → OUTPUT.
  - exp=2047 and frac=0 → saturate → OUTPUT.
  - exp=0 (zero/denormal) or e<0 → z=0 → OUTPUT.
  - e=OUT_W-1, sign=1, frac=0 → z=-2^(OUT_W-1), z_ovf=0 → OUTPUT.
  - e≥OUT_W-1 → saturate → OUTPUT.
  - Otherwise → load cnt=52-e → SHIFT.
- Saturate: z=sign ? -2^(OUT_W-1) : 2^(OUT_W-1)-1, z_ovf=1.
- SHIFT: mant<=mant>>1, cnt<=cnt-1 each cycle. When cnt=1, go to NEGATE (exactly 52-e cycles, always ≥1). Discarded bits are truncated; there is no rounding.
- NEGATE (1 cycle): z=sign ? -mant[OUT_W-1:0] : mant[OUT_W-1:0]; z_ovf=z_nan=0 → OUTPUT. A signed zero (-0.0) yields 0.
- OUTPUT: z_out_done=1; z_out, z_ovf and z_nan are stable. Go to IDLE on the cycle z_out_ack=1. a_in_done and a_in are ignored here.
- Latency, with a_in_done sampled at edge 0:
  - Normal path: z_out_done is first high in cycle 4+S, where S=52-e.
  - Special and saturate paths: z_out_done is first high in cycle 3.
- Ack and rearm:
  - z_out_ack outside OUTPUT is ignored.
  - After ack, z_out_done drops next cycle; z_out and the flags hold their last value until the next NEGATE/CLASSIFY write.
  - If a_in_done is still high in IDLE after ack, a new conversion starts. The caller drops a_in_done during its ack cycle to prevent this.
- Caller dropping a_in_done mid-conversion does not abort; the result is still presented and waits for ack.
- All outputs are registered; there are no combinational paths from input to output.

Test Plan:
- Reset, then a_in=0x3FF0000000000000 (1.0) held → z_out=0x0001, flags 0, z_out_done first high cycle 56; pulse ack → z_out_done=0 next cycle, state back to IDLE.
- a_in=0x4059300000000000 (100.75) → z_out=0x0064. a_in=0xC004000000000000 (-2.5) → z_out=0xFFFE. a_in=0x3FE0000000000000 (0.5) → 0x0000 at cycle 3.
- a_in=0x40E3880000000000 (40000.0) → z_out=0x7FFF, z_ovf=1, done at cycle 3. a_in=0xC0E0000000000000 (-32768.0) → 0x8000, z_ovf=0. a_in=0xFFF0000000000000 (-Inf) → 0x8000, z_ovf=1.
- a_in=0x7FF8000000000000 (NaN) → z_out=0, z_nan=1. a_in=0x8000000000000000 (-0.0) → 0, flags 0.
- Hold z_out_ack=0 for 20 cycles in OUTPUT while toggling a_in → z_out and z_out_done stay stable. Ack while a_in_done=1 → new conversion starts immediately.
- Assert reset during SHIFT (cycle 10 of a 1.0 conversion) → next cycle IDLE, all outputs 0, no z_out_done. A following conversion of 1.0 completes normally.
